// File: rtl/event_unit_pkg.sv
// rtl/event_unit_pkg.sv - shared types and constants for the event unit sleep controller
// Contents:
//   eu_state_e       : sleep controller FSM states
//   EVNT_W_DEFAULT   : default event status/clear width
//   TIMEOUT_FLAG_BIT : rdata bit carrying the timeout-wake flag at the default width
package event_unit_pkg;

    localparam int EVNT_W_DEFAULT   = 32;
    localparam int TIMEOUT_FLAG_BIT = EVNT_W_DEFAULT - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_SLEEP = 3'd2,
        ST_WAKE  = 3'd3,
        ST_RESP  = 3'd4
    } eu_state_e;

endpackage

// File: rtl/event_unit_sleep_timer.sv
// rtl/event_unit_sleep_timer.sv - sleep timeout down-counter for the event unit
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load load_val_i (asserted on the cycle the FSM enters SLEEP)
//   load_val_i    : timeout in SLEEP cycles, 0 = never expire
//   active_i      : FSM is in SLEEP; counter decrements while set
//   expire_o      : last SLEEP cycle of the timeout window (count == 1)
module event_unit_sleep_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMO_W-1:0] load_val_i,
    input  logic             active_i,
    output logic             expire_o
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (active_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Loading N yields N SLEEP cycles (N..1); a load of 0 parks at 0 and never fires.
    assign expire_o = active_i && (count_q == {{(TMO_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/event_unit_sleep_ctrl.sv
// rtl/event_unit_sleep_ctrl.sv - core wait-for-event sleep controller with clock gating
// Optional feature macro: EU_SLEEP_TIMEOUT_EN (adds timeout_cycles_i and the sleep timer)
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   core_wait_req_i/gnt_o    : wait request / combinational grant (IDLE only)
//   core_wait_r_valid_o      : one-cycle response pulse
//   core_wait_r_rdata_o      : latched event status, top bit = timeout flag
//   core_busy_i              : core has outstanding transactions
//   clock_en_o               : registered core clock-gate enable (0 only in SLEEP)
//   event_detect_i           : masked event pending
//   event_status_i           : masked buffered event status
//   clear_on_wake_i          : clear serviced events in RESP
//   evnt_buffer_clear_o      : per-bit event buffer clear pulse
//   timeout_cycles_i         : sleep timeout, 0 = disabled (EU_SLEEP_TIMEOUT_EN only)
module event_unit_sleep_ctrl
    import event_unit_pkg::*;
#(
    parameter int EVNT_W = EVNT_W_DEFAULT,
    parameter int TMO_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_wait_req_i,
    output logic              core_wait_gnt_o,
    output logic              core_wait_r_valid_o,
    output logic [EVNT_W-1:0] core_wait_r_rdata_o,
    input  logic              core_busy_i,
    output logic              clock_en_o,
    input  logic              event_detect_i,
    input  logic [EVNT_W-1:0] event_status_i,
    input  logic              clear_on_wake_i,
    output logic [EVNT_W-1:0] evnt_buffer_clear_o
`ifdef EU_SLEEP_TIMEOUT_EN
    ,
    input  logic [TMO_W-1:0]  timeout_cycles_i
`endif
);

    localparam int FLAG_BIT = (EVNT_W == EVNT_W_DEFAULT) ? TIMEOUT_FLAG_BIT : EVNT_W - 1;

    eu_state_e         state_q, state_d;
    logic [EVNT_W-1:0] status_q, status_d;
    logic              tmo_wake_q, tmo_wake_d;
    logic              clock_en_q;
    logic              tmo_expire;

`ifdef EU_SLEEP_TIMEOUT_EN
    event_unit_sleep_timer #(
        .TMO_W (TMO_W)
    ) u_sleep_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_q != ST_SLEEP) && (state_d == ST_SLEEP)),
        .load_val_i (timeout_cycles_i),
        .active_i   (state_q == ST_SLEEP),
        .expire_o   (tmo_expire)
    );
`else
    // No timer in this build: expiry is constant-false, SLEEP exits on events only.
    localparam logic [TMO_W-1:0] TMO_NONE = '0;
    assign tmo_expire = (TMO_NONE != '0);
`endif

    assign core_wait_gnt_o = (state_q == ST_IDLE) && core_wait_req_i;

    always_comb begin
        state_d    = state_q;
        tmo_wake_d = tmo_wake_q;
        status_d   = status_q;

        case (state_q)
            ST_IDLE: begin
                if (core_wait_gnt_o) begin
                    state_d    = event_detect_i ? ST_RESP : ST_DRAIN;
                    tmo_wake_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // A pending event short-circuits the drain; no need to sleep.
                if (event_detect_i) begin
                    state_d = ST_RESP;
                end else if (!core_busy_i) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                // Event beats a simultaneous timeout expiry.
                if (event_detect_i) begin
                    state_d    = ST_WAKE;
                    tmo_wake_d = 1'b0;
                end else if (tmo_expire) begin
                    state_d    = ST_WAKE;
                    tmo_wake_d = 1'b1;
                end
            end
            ST_WAKE:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Capture status on the cycle the FSM moves into RESP; the top bit
        // is owned by the controller, never by the event mux.
        if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
            status_d           = event_status_i;
            status_d[FLAG_BIT] = (state_q == ST_WAKE) && tmo_wake_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            status_q   <= '0;
            tmo_wake_q <= 1'b0;
            clock_en_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            tmo_wake_q <= tmo_wake_d;
            // Registered from next state so the gate opens on the same edge
            // that leaves SLEEP and closes on the edge that enters it.
            clock_en_q <= (state_d != ST_SLEEP);
        end
    end

    assign clock_en_o          = clock_en_q;
    assign core_wait_r_valid_o = (state_q == ST_RESP);
    assign core_wait_r_rdata_o = status_q;

    always_comb begin
        evnt_buffer_clear_o = '0;
        if ((state_q == ST_RESP) && clear_on_wake_i) begin
            evnt_buffer_clear_o           = status_q;
            evnt_buffer_clear_o[FLAG_BIT] = 1'b0;
        end
    end

endmodule

// File: tb/tb_event_unit_sleep_ctrl.sv
// tb/tb_event_unit_sleep_ctrl.sv - directed self-checking bench for event_unit_sleep_ctrl
module tb_event_unit_sleep_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_wait_req_i;
    logic        core_wait_gnt_o;
    logic        core_wait_r_valid_o;
    logic [31:0] core_wait_r_rdata_o;
    logic        core_busy_i;
    logic        clock_en_o;
    logic        event_detect_i;
    logic [31:0] event_status_i;
    logic        clear_on_wake_i;
    logic [31:0] evnt_buffer_clear_o;
`ifdef EU_SLEEP_TIMEOUT_EN
    logic [15:0] timeout_cycles_i;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    event_unit_sleep_ctrl #(
        .EVNT_W (32),
        .TMO_W  (16)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .core_wait_req_i     (core_wait_req_i),
        .core_wait_gnt_o     (core_wait_gnt_o),
        .core_wait_r_valid_o (core_wait_r_valid_o),
        .core_wait_r_rdata_o (core_wait_r_rdata_o),
        .core_busy_i         (core_busy_i),
        .clock_en_o          (clock_en_o),
        .event_detect_i      (event_detect_i),
        .event_status_i      (event_status_i),
        .clear_on_wake_i     (clear_on_wake_i),
        .evnt_buffer_clear_o (evnt_buffer_clear_o)
`ifdef EU_SLEEP_TIMEOUT_EN
        ,
        .timeout_cycles_i    (timeout_cycles_i)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i           = 1'b1;
        core_wait_req_i = 1'b0;
        core_busy_i     = 1'b0;
        event_detect_i  = 1'b0;
        event_status_i  = '0;
        clear_on_wake_i = 1'b1;
`ifdef EU_SLEEP_TIMEOUT_EN
        timeout_cycles_i = '0;
`endif
        tick();
        tick();
        check_eq("rst_clk_en", 32'(clock_en_o), 32'd1);
        check_eq("rst_rvalid", 32'(core_wait_r_valid_o), 32'd0);
        check_eq("rst_rdata", core_wait_r_rdata_o, 32'h0);
        check_eq("rst_clear", evnt_buffer_clear_o, 32'h0);
        check_eq("rst_gnt", 32'(core_wait_gnt_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // Event already pending: response the next cycle, no sleep.
        core_wait_req_i = 1'b1;
        event_detect_i  = 1'b1;
        event_status_i  = 32'h0000_0004;
        settle();
        check_eq("fast_gnt", 32'(core_wait_gnt_o), 32'd1);
        check_eq("fast_rvalid_c0", 32'(core_wait_r_valid_o), 32'd0);
        tick();
        check_eq("fast_gnt_in_resp", 32'(core_wait_gnt_o), 32'd0);
        check_eq("fast_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("fast_rdata", core_wait_r_rdata_o, 32'h4);
        check_eq("fast_clear", evnt_buffer_clear_o, 32'h4);
        check_eq("fast_clk_en", 32'(clock_en_o), 32'd1);
        core_wait_req_i = 1'b0;
        event_detect_i  = 1'b0;
        event_status_i  = '0;
        tick();
        check_eq("fast_rvalid_off", 32'(core_wait_r_valid_o), 32'd0);
        check_eq("fast_rdata_hold", core_wait_r_rdata_o, 32'h4);
        check_eq("fast_clear_off", evnt_buffer_clear_o, 32'h0);

        // Drain 3 busy cycles, sleep on cycle 5, wake on event 0x10.
        core_wait_req_i = 1'b1;
        core_busy_i     = 1'b1;
        settle();
        check_eq("sleep_gnt", 32'(core_wait_gnt_o), 32'd1);
        tick();
        check_eq("drain_gnt_ignored", 32'(core_wait_gnt_o), 32'd0);
        check_eq("drain_clk_en", 32'(clock_en_o), 32'd1);
        core_wait_req_i = 1'b0;
        tick();
        tick();
        check_eq("drain_c3_clk_en", 32'(clock_en_o), 32'd1);
        tick();
        core_busy_i = 1'b0;
        check_eq("drain_c4_clk_en", 32'(clock_en_o), 32'd1);
        tick();
        check_eq("sleep_c5_clk_en", 32'(clock_en_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("sleep_hold_clk_en", 32'(clock_en_o), 32'd0);
            check_eq("sleep_hold_rvalid", 32'(core_wait_r_valid_o), 32'd0);
        end
        event_detect_i = 1'b1;
        event_status_i = 32'h0000_0010;
        tick();
        check_eq("wake_clk_en", 32'(clock_en_o), 32'd1);
        check_eq("wake_rvalid", 32'(core_wait_r_valid_o), 32'd0);
        event_detect_i = 1'b0;
        tick();
        check_eq("wake_resp_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("wake_resp_rdata", core_wait_r_rdata_o, 32'h10);
        check_eq("wake_resp_clear", evnt_buffer_clear_o, 32'h10);
        event_status_i = '0;
        tick();
        check_eq("wake_rvalid_off", 32'(core_wait_r_valid_o), 32'd0);

        // No auto-clear.
        clear_on_wake_i = 1'b0;
        core_wait_req_i = 1'b1;
        event_detect_i  = 1'b1;
        event_status_i  = 32'h0000_0003;
        settle();
        check_eq("noclr_clear_c0", evnt_buffer_clear_o, 32'h0);
        tick();
        check_eq("noclr_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("noclr_rdata", core_wait_r_rdata_o, 32'h3);
        check_eq("noclr_clear_c1", evnt_buffer_clear_o, 32'h0);
        core_wait_req_i = 1'b0;
        event_detect_i  = 1'b0;
        event_status_i  = '0;
        tick();
        check_eq("noclr_clear_c2", evnt_buffer_clear_o, 32'h0);
        clear_on_wake_i = 1'b1;

        // Event arriving during DRAIN wins; mux-supplied top bit is dropped.
        core_wait_req_i = 1'b1;
        core_busy_i     = 1'b1;
        tick();
        core_wait_req_i = 1'b0;
        event_detect_i  = 1'b1;
        event_status_i  = 32'h8000_0020;
        tick();
        check_eq("drain_evt_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("drain_evt_rdata", core_wait_r_rdata_o, 32'h20);
        check_eq("drain_evt_clear", evnt_buffer_clear_o, 32'h20);
        event_detect_i = 1'b0;
        core_busy_i    = 1'b0;
        event_status_i = '0;
        tick();

        // Reset while asleep: clock back on, request dropped.
        core_wait_req_i = 1'b1;
        tick();
        core_wait_req_i = 1'b0;
        tick();
        check_eq("rsl_sleep_clk_en", 32'(clock_en_o), 32'd0);
        rst_i = 1'b1;
        tick();
        check_eq("rsl_clk_en", 32'(clock_en_o), 32'd1);
        check_eq("rsl_rvalid", 32'(core_wait_r_valid_o), 32'd0);
        check_eq("rsl_rdata", core_wait_r_rdata_o, 32'h0);
        rst_i          = 1'b0;
        event_detect_i = 1'b1;
        event_status_i = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rsl_no_rvalid", 32'(core_wait_r_valid_o), 32'd0);
            check_eq("rsl_idle_clk_en", 32'(clock_en_o), 32'd1);
        end
        event_detect_i = 1'b0;
        event_status_i = '0;
        tick();

`ifdef EU_SLEEP_TIMEOUT_EN
        // Timeout of 5: SLEEP cycles 2..6, WAKE 7, RESP 8 with flag.
        timeout_cycles_i = 16'd5;
        core_wait_req_i  = 1'b1;
        tick();
        core_wait_req_i = 1'b0;
        tick();
        check_eq("tmo_sleep_clk_en", 32'(clock_en_o), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("tmo_last_sleep_clk_en", 32'(clock_en_o), 32'd0);
        tick();
        check_eq("tmo_wake_clk_en", 32'(clock_en_o), 32'd1);
        tick();
        check_eq("tmo_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("tmo_rdata", core_wait_r_rdata_o, 32'h8000_0000);
        check_eq("tmo_clear", evnt_buffer_clear_o, 32'h0);
        tick();

        // Event on the expiry cycle: event wins, flag clear.
        core_wait_req_i = 1'b1;
        tick();
        core_wait_req_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        event_detect_i = 1'b1;
        event_status_i = 32'h0000_0002;
        tick();
        check_eq("tmo_evt_wake_clk_en", 32'(clock_en_o), 32'd1);
        event_detect_i = 1'b0;
        tick();
        check_eq("tmo_evt_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        check_eq("tmo_evt_rdata", core_wait_r_rdata_o, 32'h2);
        event_status_i = '0;
        tick();

        // Timeout of 0 never expires.
        timeout_cycles_i = 16'd0;
        core_wait_req_i  = 1'b1;
        tick();
        core_wait_req_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("tmo0_still_asleep", 32'(clock_en_o), 32'd0);
        event_detect_i = 1'b1;
        tick();
        event_detect_i = 1'b0;
        tick();
        check_eq("tmo0_rdata", core_wait_r_rdata_o, 32'h0);
        check_eq("tmo0_rvalid", 32'(core_wait_r_valid_o), 32'd1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
